// File: rtl/comm_arb_pkg.sv
// Shared types and helpers for the comm TX arbiter.
package comm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } arb_state_t;

  // Widest header word the length helper accepts.
  localparam int unsigned HDR_MAX_W = 64;

  // Extract the payload length field (low len_bits bits) from a header word.
  function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] word,
                                                    input int unsigned len_bits);
    logic [HDR_MAX_W-1:0] mask;
    mask = '0;
    for (int unsigned b = 0; b < HDR_MAX_W; b++) begin
      if (b < len_bits) mask[b] = 1'b1;
    end
    return word & mask;
  endfunction

endpackage

// File: rtl/comm_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest candidate down so the nearest one above ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      int c;
      c = (int'(ptr) + k) % N;
      if (req[c]) idx = IW'(c);
    end
    if (any) gnt = N'(1) << idx;
  end

endmodule

// File: rtl/comm_tx_arbiter.sv
// Packet-granular round-robin arbiter for the shared comm TX path, with a
// stall watchdog that aborts a granted packet whose source stops supplying words.
module comm_tx_arbiter
  import comm_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 16,
  parameter int LEN_BITS = 8,
  parameter int TIMEOUT  = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rd,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_wr,
  input  logic                  tx_rdy,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  abort,
  output logic [2:0]            abort_id
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic                abort_q, abort_d;
  logic [2:0]          abort_id_q, abort_id_d;

  logic [NREQ-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic [WIDTH-1:0]    cur_word;
  logic                cur_val;
  logic                xfer;
  logic                stall_tick;
  logic                stall_hit;
  logic [LEN_BITS-1:0] hdr_cnt;
  logic [IW-1:0]       ptr_next;
  logic                pkt_end;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req (req_val),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the owner's head word and valid; the loop keeps the index in range.
  always_comb begin
    cur_word = '0;
    cur_val  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == gidx_q) begin
        cur_word = req_data[i*WIDTH +: WIDTH];
        cur_val  = req_val[i];
      end
    end
  end

  assign xfer       = (state_q != ST_IDLE) && tx_rdy && cur_val;
  assign stall_tick = (state_q != ST_IDLE) && tx_rdy && !cur_val;
  assign stall_hit  = stall_tick && (stall_q == SW'(TIMEOUT - 1));
  assign hdr_cnt    = LEN_BITS'(hdr_len(HDR_MAX_W'(cur_word), LEN_BITS));
  assign ptr_next   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);

  assign tx_data  = cur_word;
  assign tx_wr    = xfer;
  assign req_rd   = xfer ? grant_q : '0;
  assign grant    = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign abort    = abort_q;
  assign abort_id = abort_id_q;

  // Next-state logic: arbitration, header/payload counting and the watchdog.
  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    abort_d    = 1'b0;
    abort_id_d = abort_id_q;
    pkt_end    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (pick_any) begin
          gidx_d  = pick_idx;
          grant_d = pick_gnt;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          stall_d = '0;
          cnt_d   = hdr_cnt;
          if (hdr_cnt == '0) pkt_end = 1'b1;
          else               state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (xfer) begin
          stall_d = '0;
          cnt_d   = cnt_q - LEN_BITS'(1);
          if (cnt_q == LEN_BITS'(1)) pkt_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stall cycle never coincides with a transfer, so a late word always wins.
    if (stall_tick) begin
      if (stall_hit) begin
        abort_d    = 1'b1;
        abort_id_d = 3'(gidx_q);
        pkt_end    = 1'b1;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end

    if (pkt_end) begin
      state_d  = ST_IDLE;
      grant_d  = '0;
      rr_ptr_d = ptr_next;
      stall_d  = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      stall_q    <= '0;
      abort_q    <= 1'b0;
      abort_id_q <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      abort_q    <= abort_d;
      abort_id_q <= abort_id_d;
    end
  end

endmodule

// File: tb/tb_comm_tx_arbiter.sv
// Scoreboard bench for comm_tx_arbiter: sources feed packet queues, a
// cycle-level reference model predicts grant/transfer/abort behaviour.
module tb_comm_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 16;
  localparam int LEN_BITS = 8;
  localparam int TIMEOUT  = 1023;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_val = '0;
  logic [NREQ-1:0]       req_rd;
  logic [WIDTH-1:0]      tx_data;
  logic                  tx_wr;
  logic                  tx_rdy = 1'b0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  abort;
  logic [2:0]            abort_id;

  comm_tx_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .LEN_BITS (LEN_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_data (req_data),
    .req_val  (req_val),
    .req_rd   (req_rd),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_rdy   (tx_rdy),
    .grant    (grant),
    .busy     (busy),
    .abort    (abort),
    .abort_id (abort_id)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Source side: words still to offer, packet sizes, progress, stall controls.
  logic [WIDTH-1:0] src_q [NREQ][$];
  logic [WIDTH-1:0] exp_q [NREQ][$];
  int               plen  [NREQ][$];
  int               sent    [NREQ];
  int               dead_at [NREQ];
  bit               dead    [NREQ];
  int               sil     [NREQ];
  int               rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit               rand_en = 1'b0;
  int               dead_events = 0;

  // Reference model state.
  bit       m_busy = 0, m_hdr = 0, m_abort = 0;
  int       m_own = 0, m_ptr = 0, m_rem = 0, m_stall = 0;
  logic [2:0] m_abid = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic enq(input int r, input logic [WIDTH-1:0] hdr);
    int n;
    logic [WIDTH-1:0] w;
    n = int'(hdr[LEN_BITS-1:0]);
    src_q[r].push_back(hdr);
    exp_q[r].push_back(hdr);
    for (int k = 0; k < n; k++) begin
      w = WIDTH'($urandom);
      src_q[r].push_back(w);
      exp_q[r].push_back(w);
    end
    plen[r].push_back(n + 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      plen[i].delete();
      sent[i] = 0; dead[i] = 0; dead_at[i] = 0; sil[i] = 0;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(all_empty() && !busy) && n < budget);
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: not idle after %0d cycles", budget);
    end
  endtask

  task automatic wait_src(input int r, input int lvl, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (src_q[r].size() > lvl && n < budget);
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_src: req%0d still holds %0d words", r, src_q[r].size());
    end
  endtask

  task automatic wait_dead(input int r, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dead[r] && n < budget);
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_dead: req%0d never stalled", r);
    end
  endtask

  // Source driver: consume popped words, apply stalls, present the next heads.
  always begin
    logic [NREQ-1:0] rd_s, gr_s;
    logic            ab_s;
    logic [2:0]      abid_s;
    int              rem, ai;
    @(negedge clock);
    rd_s = req_rd; gr_s = grant; ab_s = abort; abid_s = abort_id;
    @(posedge clock);
    #1;
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rd_s[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          sent[i]++;
          if (plen[i].size() > 0 && sent[i] == plen[i][0]) begin
            void'(plen[i].pop_front());
            sent[i] = 0;
          end
          if (dead_at[i] != 0 && sent[i] == dead_at[i]) begin
            dead[i] = 1'b1;
            dead_at[i] = 0;
          end
        end
      end
      if (ab_s) begin
        ai = int'(abid_s);
        if (ai < NREQ && plen[ai].size() > 0) begin
          rem = plen[ai][0] - sent[ai];
          repeat (rem) if (src_q[ai].size() > 0) void'(src_q[ai].pop_front());
          void'(plen[ai].pop_front());
          sent[ai] = 0;
        end
        if (ai < NREQ) begin
          dead[ai] = 1'b0;
          sil[ai] = 0;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (sil[i] > 0) sil[i]--;
        else if (rand_en && ($urandom % 100) < 2) sil[i] = 1 + int'($urandom % 30);
        if (rand_en && dead_events < 2 && gr_s[i] && !rd_s[i] && !dead[i] &&
            ($urandom % 500) == 0) begin
          dead[i] = 1'b1;
          dead_events++;
        end
      end
    end
    case (rdy_mode)
      0:       tx_rdy = 1'b0;
      1:       tx_rdy = 1'b1;
      default: tx_rdy = (($urandom % 10) < 8);
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req_val[i] = (src_q[i].size() > 0) && !dead[i] && (sil[i] == 0);
      req_data[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  end

  // Monitor: compare this cycle's outputs with the model, then advance the model.
  always @(negedge clock) begin
    bit         exp_x;
    logic [WIDTH-1:0] w;
    int         len, nd;
    bit         fin;
    if (!reset) begin
      m_busy = 0; m_hdr = 0; m_abort = 0; m_own = 0; m_ptr = 0;
      m_rem = 0; m_stall = 0; m_abid = '0;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_tx_wr", 32'(tx_wr), 32'd0);
      chk("rst_req_rd", 32'(req_rd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_abort_id", 32'(abort_id), 32'd0);
    end else begin
      exp_x = m_busy && tx_rdy && req_val[m_own];
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant", 32'(grant), m_busy ? (32'd1 << m_own) : 32'd0);
      chk("abort", 32'(abort), 32'(m_abort));
      chk("abort_id", 32'(abort_id), 32'(m_abid));
      chk("tx_wr", 32'(tx_wr), 32'(exp_x));
      chk("req_rd", 32'(req_rd), exp_x ? (32'd1 << m_own) : 32'd0);
      w = '0;
      if (exp_x) begin
        if (exp_q[m_own].size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tx_data: word %0h from req%0d not expected", tx_data, m_own);
        end else begin
          w = exp_q[m_own].pop_front();
          chk("tx_data", 32'(tx_data), 32'(w));
        end
      end
      m_abort = 0;
      fin = 0;
      if (!m_busy) begin
        if (|req_val) begin
          m_own = model_pick(req_val, m_ptr);
          m_busy = 1; m_hdr = 1; m_stall = 0;
        end
      end else if (exp_x) begin
        m_stall = 0;
        if (m_hdr) begin
          len = int'(w[LEN_BITS-1:0]);
          if (len == 0) fin = 1;
          else begin m_rem = len; m_hdr = 0; end
        end else begin
          m_rem--;
          if (m_rem == 0) fin = 1;
        end
      end else if (tx_rdy) begin
        m_stall++;
        if (m_stall == TIMEOUT) begin
          if (m_hdr) nd = (exp_q[m_own].size() > 0) ? 1 + int'(exp_q[m_own][0][LEN_BITS-1:0]) : 0;
          else       nd = m_rem;
          repeat (nd) if (exp_q[m_own].size() > 0) void'(exp_q[m_own].pop_front());
          m_abort = 1;
          m_abid = 3'(m_own);
          fin = 1;
        end
      end
      if (fin) begin
        m_busy = 0;
        m_ptr = (m_own + 1) % NREQ;
      end
    end
  end

  initial begin
    clear_all();
    reset = 1'b0;
    rdy_mode = 1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    // Single 3-word-payload packet from req0.
    @(posedge clock); #2;
    enq(0, 16'h0003);
    wait_idle(100);

    // Zero-length packet.
    @(posedge clock); #2;
    enq(0, 16'hAB00);
    wait_idle(100);

    // All four requesters competing with one-word packets.
    @(posedge clock); #2;
    for (int r = 0; r < NREQ; r++) repeat (3) enq(r, 16'h0000);
    wait_idle(200);

    // Long backpressure mid-payload must not trip the watchdog.
    @(posedge clock); #2;
    enq(1, 16'h0004);
    wait_src(1, 3, 100);
    rdy_mode = 0;
    repeat (2000) @(posedge clock);
    #2 rdy_mode = 1;
    wait_idle(100);

    // req2 stalls after header + one payload word; req3 should win next.
    @(posedge clock); #2;
    dead_at[2] = 2;
    enq(2, 16'h0005);
    wait_dead(2, 100);
    @(posedge clock); #2;
    enq(3, 16'h0000);
    enq(0, 16'h0000);
    wait_idle(3000);

    // Asynchronous reset in the middle of a payload.
    @(posedge clock); #2;
    enq(0, 16'h0006);
    wait_src(0, 4, 100);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_tx_wr", 32'(tx_wr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    #2 clear_all();
    @(posedge clock); #2;
    reset = 1'b1;
    enq(0, 16'h0000);
    enq(1, 16'h0000);
    wait_idle(100);

    // Randomized traffic with random backpressure and stalls.
    @(posedge clock); #2;
    rand_en = 1'b1;
    rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, NREQ - 1));
      if (($urandom % 10) == 0 && src_q[r].size() < 24)
        enq(r, {8'($urandom), 8'($urandom % 7)});
      @(posedge clock); #2;
    end
    rand_en = 1'b0;
    rdy_mode = 1;
    wait_idle(10000);

    for (int r = 0; r < NREQ; r++) chk("drain", 32'(exp_q[r].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comm_tx_arbiter.md
Name: comm_tx_arbiter

Overview:
- Shares the single comm TX path (tx_data/tx_wr/tx_rdy of the SERDES wrapper) between NREQ packet sources.
- Round-robin arbitration at packet granularity: once granted, a requester keeps the TX path until its whole packet (header + payload) has been queued.
- A stall watchdog aborts a granted packet whose source stops supplying words, so one failed requester cannot block the link.
- Sits in the main clock domain between command/telemetry producers and the comm block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, word width; matches comm WIDTH
- LEN_BITS, 8, header field holding payload word count; header[LEN_BITS-1:0]
- TIMEOUT, 1023, max consecutive stall cycles while granted before abort (>=1)

Ports:
- clock  in  1  main clock
- reset  in  1  asynchronous, active-low reset
- req_data  in  NREQ*WIDTH  per-requester head-of-queue word; slice i = [i*WIDTH +: WIDTH]
- req_val  in  NREQ  requester i has a word at its head
- req_rd  out  NREQ  pop strobe; requester i's word is consumed this cycle
- tx_data  out  WIDTH  to comm tx_data
- tx_wr  out  1  to comm tx_wr
- tx_rdy  in  1  from comm tx_rdy
- grant  out  NREQ  one-hot owner; all zero when idle
- busy  out  1  packet in progress
- abort  out  1  one-cycle pulse when the watchdog aborts a packet
- abort_id  out  3  index of the aborted requester; valid with abort, held until the next abort

Behaviour:
- Reset (reset=0, async): state IDLE; rr_ptr=0; grant=0; busy=0; abort=0; abort_id=0; stall count=0; word count=0; tx_wr=0; req_rd=0.
- States: IDLE, HDR, PAY.
- IDLE:
  - If any req_val is set, choose the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register grant; go to HDR.
  - No words move in IDLE, so arbitration costs 1 cycle.
- Transfer rule (HDR and PAY):
  - xfer = tx_rdy & req_val[g].
  - tx_wr = xfer; req_rd[g] = xfer; all other req_rd stay 0.
  - tx_data = req_data[g], combinational.
  - tx_wr is never asserted when tx_rdy=0.
- HDR:
  - On xfer, latch count = header[LEN_BITS-1:0].
  - count==0: packet ends; go to IDLE.
  - Otherwise go to PAY.
- PAY:
  - On xfer, decrement count.
  - On xfer with count==1: packet ends; go to IDLE.
- Packet end or abort: rr_ptr = (g+1) mod NREQ; grant cleared the next cycle.
  - The same requester cannot win twice in a row while another requester has req_val set.
- Watchdog:
  - Counts cycles in HDR/PAY with req_val[g]=0 and tx_rdy=1.
  - Resets to 0 on any xfer and on entry to HDR.
  - tx_rdy=0 (backpressure) holds the count; it does not increment.
  - When the count reaches TIMEOUT: abort=1 for 1 cycle, abort_id=g, go to IDLE.
  - A partially sent packet is left truncated; the downstream protocol detects this. The arbiter does not drain the remainder.
- busy = (state != IDLE).
- Back-to-back packets: IDLE→HDR takes 1 cycle, so sustained throughput is one word per cycle, minus one cycle per packet.
- Requester dropping req_val mid-packet is legal (stall); only the watchdog ends it.
- req_val[g] deasserted and TIMEOUT reached in the same cycle as a late xfer: the xfer wins and the counter resets.
- Reset asserted mid-packet: immediate return to reset state; a partial packet may remain in the TX FIFO (system-level reset clears it too).

Decomposition:
- Package comm_arb_pkg:
  - state enum (IDLE/HDR/PAY)
  - helper function hdr_len(word) extracting the length field
- Sub-module rr_pick #(N):
  - combinational round-robin picker
  - inputs: request vector, pointer
  - outputs: one-hot grant, index, any
  - unit-testable on its own
- Top holds the FSM, counters and datapath mux.

Test Plan:
- Single packet: req0 presents header 0x0003 + 3 payload words, tx_rdy=1 → grant=0001 one cycle after req_val; 4 consecutive tx_wr carrying exactly those words; busy clears; 5 cycles total.
- Zero-length packet: header 0xAB00 → single tx_wr of 0xAB00; returns to IDLE; rr_ptr=1.
- Round-robin: req0..3 continuously present 1-word packets (header 0x0000) → grant sequence 0,1,2,3,0,…; no requester is granted twice while others wait.
- Backpressure: tx_rdy=0 for 2000 cycles mid-payload (TIMEOUT=1023) → no tx_wr, no abort; transfer resumes when tx_rdy returns to 1.
- Stall abort: req2 sends header 0x0005 and 1 payload word, then drops req_val → after 1023 stall cycles abort pulses with abort_id=2; next grant goes to req3 if requesting.
- Async reset mid-PAY → grant=0, tx_wr=0 immediately; after release, req0 (rr_ptr=0) wins a tie.
